id_ex_stage: RTL and testbench

// Decode/issue stage register feeding the 64-bit gate-level ALU in EX. Decodes a 32-bit RV64I-subset

---
 rtl/id_ex_stage_pkg.sv | 39 +++
 rtl/id_ex_stage_imm_gen.sv | 27 ++
 rtl/id_ex_stage.sv | 196 +++++++++++++++++++
 tb/tb_id_ex_stage.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared ALU function codes, opcode constants and decode types for the ID/EX stage.
package id_ex_stage_pkg;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4;
   localparam logic [3:0] ALU_SLL  = 4'd5;
   localparam logic [3:0] ALU_SRL  = 4'd6;
   localparam logic [3:0] ALU_SRA  = 4'd7;
   localparam logic [3:0] ALU_SLT  = 4'd8;
   localparam logic [3:0] ALU_SLTU = 4'd9;

   localparam logic [6:0] OP_R  = 7'b0110011;
   localparam logic [6:0] OP_I  = 7'b0010011;
   localparam logic [6:0] OP_LD = 7'b0000011;
   localparam logic [6:0] OP_ST = 7'b0100011;
   localparam logic [6:0] OP_BR = 7'b1100011;

   localparam logic [2:0] F3_DWORD = 3'b011;
   localparam logic [2:0] F3_BEQ   = 3'b000;

   typedef enum logic [1:0] {
      IMM_NONE = 2'd0,
      IMM_I    = 2'd1,
      IMM_S    = 2'd2,
      IMM_B    = 2'd3
   } imm_sel_e;

   typedef struct packed {
      logic reg_write;
      logic mem_read;
      logic mem_write;
      logic branch;
      logic illegal;
   } ctrl_t;

endpackage

// File: rtl/id_ex_stage_imm_gen.sv
// imm_gen: sign-extends the I/S/B immediate selected by decode; purely combinational.
// No latency, no flow control.
module imm_gen
   import id_ex_stage_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic [31:0]     instr,
   input  imm_sel_e        imm_sel,
   output logic [XLEN-1:0] imm
);

   // Opcode and rs1/funct3 bits never carry immediate data.
   logic unused_bits;
   assign unused_bits = ^{instr[19:12], instr[6:0]};

   always_comb begin
      imm = '0;
      case (imm_sel)
         IMM_I:   imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
         IMM_S:   imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
         IMM_B:   imm = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         default: imm = '0;
      endcase
   end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: RV64I-subset decode and ID/EX pipeline register feeding the 64-bit ALU.
// 1-cycle latency; stall holds the slot, flush or an empty input slot loads a bubble.
module id_ex_stage
   import id_ex_stage_pkg::*;
#(
   parameter int XLEN = 64,
   parameter int ILEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   input  logic [ILEN-1:0] in_instr,
   input  logic [XLEN-1:0] in_pc,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   input  logic            stall,
   input  logic            flush,
   output logic            ex_valid,
   output logic [XLEN-1:0] ex_pc,
   output logic [XLEN-1:0] ex_op_a,
   output logic [XLEN-1:0] ex_op_b,
   output logic [XLEN-1:0] ex_rs2_data,
   output logic [XLEN-1:0] ex_imm,
   output logic [3:0]      ex_alu_sel,
   output logic [4:0]      ex_rd,
   output logic            ex_reg_write,
   output logic            ex_mem_read,
   output logic            ex_mem_write,
   output logic            ex_branch,
   output logic            ex_illegal
);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic [5:0] funct6;
   logic [4:0] rd_field;

   assign opcode   = in_instr[6:0];
   assign rd_field = in_instr[11:7];
   assign funct3   = in_instr[14:12];
   assign funct7   = in_instr[31:25];
   assign funct6   = in_instr[31:26];

   logic            legal;
   logic            writes_rd;
   logic            use_imm;
   logic            mem_read_d;
   logic            mem_write_d;
   logic            branch_d;
   logic [3:0]      alu_sel_d;
   imm_sel_e        imm_sel_d;
   logic [XLEN-1:0] imm_d;
   ctrl_t           ctrl_d;
   ctrl_t           ctrl_q;

   always_comb begin
      legal       = 1'b0;
      writes_rd   = 1'b0;
      use_imm     = 1'b0;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
      branch_d    = 1'b0;
      alu_sel_d   = ALU_ADD;
      imm_sel_d   = IMM_NONE;

      case (opcode)
         OP_R: begin
            legal     = 1'b1;
            writes_rd = 1'b1;
            case ({funct7, funct3})
               {7'b0000000, 3'b000}: alu_sel_d = ALU_ADD;
               {7'b0100000, 3'b000}: alu_sel_d = ALU_SUB;
               {7'b0000000, 3'b001}: alu_sel_d = ALU_SLL;
               {7'b0000000, 3'b010}: alu_sel_d = ALU_SLT;
               {7'b0000000, 3'b011}: alu_sel_d = ALU_SLTU;
               {7'b0000000, 3'b100}: alu_sel_d = ALU_XOR;
               {7'b0000000, 3'b101}: alu_sel_d = ALU_SRL;
               {7'b0100000, 3'b101}: alu_sel_d = ALU_SRA;
               {7'b0000000, 3'b110}: alu_sel_d = ALU_OR;
               {7'b0000000, 3'b111}: alu_sel_d = ALU_AND;
               default:              legal     = 1'b0;
            endcase
         end
         OP_I: begin
            legal     = 1'b1;
            writes_rd = 1'b1;
            use_imm   = 1'b1;
            imm_sel_d = IMM_I;
            case (funct3)
               3'b000: alu_sel_d = ALU_ADD;
               3'b010: alu_sel_d = ALU_SLT;
               3'b011: alu_sel_d = ALU_SLTU;
               3'b100: alu_sel_d = ALU_XOR;
               3'b110: alu_sel_d = ALU_OR;
               3'b111: alu_sel_d = ALU_AND;
               3'b001: begin
                  alu_sel_d = ALU_SLL;
                  legal     = (funct6 == 6'b000000);
               end
               3'b101: begin
                  // RV64 shamt is 6 bits, so funct6 (not funct7) selects srli/srai.
                  alu_sel_d = funct6[4] ? ALU_SRA : ALU_SRL;
                  legal     = (funct6 == 6'b000000) || (funct6 == 6'b010000);
               end
               default: legal = 1'b0;
            endcase
         end
         OP_LD: begin
            if (funct3 == F3_DWORD) begin
               legal      = 1'b1;
               writes_rd  = 1'b1;
               use_imm    = 1'b1;
               imm_sel_d  = IMM_I;
               mem_read_d = 1'b1;
            end
         end
         OP_ST: begin
            if (funct3 == F3_DWORD) begin
               legal       = 1'b1;
               use_imm     = 1'b1;
               imm_sel_d   = IMM_S;
               mem_write_d = 1'b1;
            end
         end
         OP_BR: begin
            if (funct3 == F3_BEQ) begin
               legal     = 1'b1;
               alu_sel_d = ALU_SUB;
               imm_sel_d = IMM_B;
               branch_d  = 1'b1;
            end
         end
         default: legal = 1'b0;
      endcase

      // Unsupported encodings travel down the pipe as a harmless ADD with no side effects.
      if (!legal) begin
         writes_rd   = 1'b0;
         use_imm     = 1'b0;
         mem_read_d  = 1'b0;
         mem_write_d = 1'b0;
         branch_d    = 1'b0;
         alu_sel_d   = ALU_ADD;
         imm_sel_d   = IMM_NONE;
      end
   end

   imm_gen #(
      .XLEN (XLEN)
   ) u_imm_gen (
      .instr   (in_instr),
      .imm_sel (imm_sel_d),
      .imm     (imm_d)
   );

   always_comb begin
      ctrl_d           = '0;
      ctrl_d.reg_write = writes_rd && (rd_field != 5'd0);
      ctrl_d.mem_read  = mem_read_d;
      ctrl_d.mem_write = mem_write_d;
      ctrl_d.branch    = branch_d;
      ctrl_d.illegal   = !legal;
   end

   always_ff @(posedge clk) begin
      if (rst || flush || (!stall && !in_valid)) begin
         ex_valid    <= 1'b0;
         ex_pc       <= '0;
         ex_op_a     <= '0;
         ex_op_b     <= '0;
         ex_rs2_data <= '0;
         ex_imm      <= '0;
         ex_alu_sel  <= ALU_ADD;
         ex_rd       <= '0;
         ctrl_q      <= '0;
      end else if (!stall) begin
         ex_valid    <= 1'b1;
         ex_pc       <= in_pc;
         ex_op_a     <= rs1_data;
         ex_op_b     <= use_imm ? imm_d : rs2_data;
         ex_rs2_data <= rs2_data;
         ex_imm      <= imm_d;
         ex_alu_sel  <= alu_sel_d;
         ex_rd       <= writes_rd ? rd_field : 5'd0;
         ctrl_q      <= ctrl_d;
      end
   end

   assign ex_reg_write = ctrl_q.reg_write;
   assign ex_mem_read  = ctrl_q.mem_read;
   assign ex_mem_write = ctrl_q.mem_write;
   assign ex_branch    = ctrl_q.branch;
   assign ex_illegal   = ctrl_q.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: mnemonic-level reference model checked every cycle,
// plus hand-computed expectations for the key instruction words.
module tb_id_ex_stage;

   localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_AND = 4'd2, A_OR = 4'd3, A_XOR = 4'd4;
   localparam logic [3:0] A_SLL = 4'd5, A_SRL = 4'd6, A_SRA = 4'd7, A_SLT = 4'd8, A_SLTU = 4'd9;

   logic        clk = 1'b0;
   logic        rst, in_valid, stall, flush;
   logic [31:0] in_instr;
   logic [63:0] in_pc, rs1_data, rs2_data;
   logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_illegal;
   logic [63:0] ex_pc, ex_op_a, ex_op_b, ex_rs2_data, ex_imm;
   logic [3:0]  ex_alu_sel;
   logic [4:0]  ex_rd;

   id_ex_stage dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc),
      .rs1_data(rs1_data), .rs2_data(rs2_data), .stall(stall), .flush(flush),
      .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_op_a(ex_op_a), .ex_op_b(ex_op_b),
      .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_alu_sel(ex_alu_sel), .ex_rd(ex_rd),
      .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
      .ex_branch(ex_branch), .ex_illegal(ex_illegal)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: identify the mnemonic from the ISA mask/match table, then apply its semantics.
   typedef struct packed {
      logic        valid;
      logic [63:0] pc, op_a, op_b, rs2d, imm;
      logic [3:0]  alu;
      logic [4:0]  rd;
      logic        rw, mr, mw, br, ill;
   } slot_t;

   logic [31:0] pmask  [19];
   logic [31:0] pmatch [19];
   string       pname  [19];

   initial begin
      pname  = '{"add", "sub", "sll", "slt", "sltu", "xor", "srl", "sra", "or", "and",
                 "addi", "slti", "sltiu", "xori", "ori", "andi", "ld", "sd", "beq"};
      pmatch = '{32'h00000033, 32'h40000033, 32'h00001033, 32'h00002033, 32'h00003033,
                 32'h00004033, 32'h00005033, 32'h40005033, 32'h00006033, 32'h00007033,
                 32'h00000013, 32'h00002013, 32'h00003013, 32'h00004013, 32'h00006013,
                 32'h00007013, 32'h00003003, 32'h00003023, 32'h00000063};
      for (int i = 0; i < 19; i++) pmask[i] = (i < 10) ? 32'hFE00707F : 32'h0000707F;
   end

   function automatic string mnemonic(input logic [31:0] w);
      string m;
      m = "";
      for (int i = 0; i < 19; i++)
         if ((w & pmask[i]) == pmatch[i]) m = pname[i];
      if ((w & 32'hFC00707F) == 32'h00001013) m = "slli";
      if ((w & 32'hFC00707F) == 32'h00005013) m = "srli";
      if ((w & 32'hFC00707F) == 32'h40005013) m = "srai";
      return m;
   endfunction

   function automatic slot_t model(input logic [31:0] w, input logic [63:0] pc, a, b);
      slot_t   s;
      string   m;
      longint  i_imm, s_imm, b_imm;
      logic    writes;
      i_imm = longint'(w[31:20]);
      s_imm = longint'({w[31:25], w[11:7]});
      b_imm = longint'({w[31], w[7], w[30:25], w[11:8], 1'b0});
      if (w[31]) begin
         i_imm -= 4096;
         s_imm -= 4096;
         b_imm -= 8192;
      end
      m = mnemonic(w);
      s = '0;
      s.valid = 1'b1;
      s.pc    = pc;
      s.op_a  = a;
      s.op_b  = b;
      s.rs2d  = b;
      case (m)
         "add", "addi", "ld", "sd", "": s.alu = A_ADD;
         "sub", "beq":                  s.alu = A_SUB;
         "and", "andi":                 s.alu = A_AND;
         "or", "ori":                   s.alu = A_OR;
         "xor", "xori":                 s.alu = A_XOR;
         "sll", "slli":                 s.alu = A_SLL;
         "srl", "srli":                 s.alu = A_SRL;
         "sra", "srai":                 s.alu = A_SRA;
         "slt", "slti":                 s.alu = A_SLT;
         default:                       s.alu = A_SLTU;
      endcase
      if (m == "") begin
         s.ill = 1'b1;
         return s;
      end
      if (w[6:0] == 7'h13 || m == "ld") begin
         s.op_b = i_imm;
         s.imm  = i_imm;
      end
      if (m == "sd") begin
         s.op_b = s_imm;
         s.imm  = s_imm;
         s.mw   = 1'b1;
      end
      if (m == "beq") begin
         s.imm = b_imm;
         s.br  = 1'b1;
      end
      s.mr   = (m == "ld");
      writes = (m != "sd") && (m != "beq");
      s.rd   = writes ? w[11:7] : 5'd0;
      s.rw   = writes && (w[11:7] != 5'd0);
      return s;
   endfunction

   slot_t exp_s;
   logic  model_live = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         exp_s      = '0;
         model_live = 1'b1;
      end else if (flush || (!stall && !in_valid)) begin
         exp_s = '0;
      end else if (!stall) begin
         exp_s = model(in_instr, in_pc, rs1_data, rs2_data);
      end
   end

   always @(negedge clk) begin
      if (model_live) begin
         check("cmp_valid",     64'(ex_valid),     64'(exp_s.valid));
         check("cmp_pc",        ex_pc,             exp_s.pc);
         check("cmp_op_a",      ex_op_a,           exp_s.op_a);
         check("cmp_op_b",      ex_op_b,           exp_s.op_b);
         check("cmp_rs2_data",  ex_rs2_data,       exp_s.rs2d);
         check("cmp_imm",       ex_imm,            exp_s.imm);
         check("cmp_alu_sel",   64'(ex_alu_sel),   64'(exp_s.alu));
         check("cmp_rd",        64'(ex_rd),        64'(exp_s.rd));
         check("cmp_reg_write", 64'(ex_reg_write), 64'(exp_s.rw));
         check("cmp_mem_read",  64'(ex_mem_read),  64'(exp_s.mr));
         check("cmp_mem_write", 64'(ex_mem_write), 64'(exp_s.mw));
         check("cmp_branch",    64'(ex_branch),    64'(exp_s.br));
         check("cmp_illegal",   64'(ex_illegal),   64'(exp_s.ill));
      end
   end

   logic [63:0] pc_next = 64'h1000;

   // Drive one cycle of inputs at the falling edge; returns one falling edge later with the capture visible.
   task automatic cyc(input logic v, input logic [31:0] w, input logic [63:0] a, input logic [63:0] b,
                      input logic st, input logic fl, input logic r);
      rst      = r;
      in_valid = v;
      in_instr = w;
      rs1_data = a;
      rs2_data = b;
      stall    = st;
      flush    = fl;
      in_pc    = pc_next;
      pc_next  = pc_next + 64'd4;
      @(negedge clk);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_valid"}, 64'(ex_valid), 64'd0);
      check({tag, "_op_b"},  ex_op_b,       64'd0);
      check({tag, "_pc"},    ex_pc,         64'd0);
      check({tag, "_ctrl"},  64'({ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_illegal}), 64'd0);
      check({tag, "_alu"},   64'(ex_alu_sel), 64'd0);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0;
      rs1_data = '0; rs2_data = '0; stall = 1'b0; flush = 1'b0;
      @(negedge clk);
      check_all_zero("reset");

      // add x3,x1,x2
      cyc(1, 32'h002081B3, 64'd5, 64'd7, 0, 0, 0);
      check("t1_valid", 64'(ex_valid), 64'd1);
      check("t1_alu",   64'(ex_alu_sel), 64'(A_ADD));
      check("t1_op_a",  ex_op_a, 64'd5);
      check("t1_op_b",  ex_op_b, 64'd7);
      check("t1_rd",    64'(ex_rd), 64'd3);
      check("t1_rw",    64'(ex_reg_write), 64'd1);

      // addi x5,x0,-1
      cyc(1, 32'hFFF00293, 64'd0, 64'd9, 0, 0, 0);
      check("t2_op_b", ex_op_b, 64'hFFFF_FFFF_FFFF_FFFF);
      check("t2_rd",   64'(ex_rd), 64'd5);
      check("t2_rw",   64'(ex_reg_write), 64'd1);

      // srai / srli x1,x1,63
      cyc(1, 32'h43F0D093, 64'hF000_0000_0000_0000, 64'd0, 0, 0, 0);
      check("t3_sra_alu",   64'(ex_alu_sel), 64'(A_SRA));
      check("t3_sra_shamt", 64'(ex_op_b[5:0]), 64'd63);
      cyc(1, 32'h03F0D093, 64'd1, 64'd0, 0, 0, 0);
      check("t3_srl_alu",   64'(ex_alu_sel), 64'(A_SRL));

      // sd x2,8(x1)
      cyc(1, 32'h0020B423, 64'h100, 64'hDEAD, 0, 0, 0);
      check("t4_op_b", ex_op_b, 64'd8);
      check("t4_mw",   64'(ex_mem_write), 64'd1);
      check("t4_rw",   64'(ex_reg_write), 64'd0);
      check("t4_rs2",  ex_rs2_data, 64'hDEAD);

      // Stall holds the captured add while new words arrive, then stall+flush bubbles.
      cyc(1, 32'h002081B3, 64'd11, 64'd22, 0, 0, 0);
      cyc(1, 32'hFFF00293, 64'd1, 64'd2, 1, 0, 0);
      cyc(1, 32'h0020B423, 64'd3, 64'd4, 1, 0, 0);
      cyc(0, 32'h00000000, 64'd5, 64'd6, 1, 0, 0);
      check("t5_hold_op_a", ex_op_a, 64'd11);
      check("t5_hold_op_b", ex_op_b, 64'd22);
      check("t5_hold_rd",   64'(ex_rd), 64'd3);
      cyc(1, 32'h002081B3, 64'd7, 64'd8, 1, 1, 0);
      check_all_zero("t5_flush");

      // All-zero word is illegal
      cyc(1, 32'h00000000, 64'd1, 64'd2, 0, 0, 0);
      check("t6_valid", 64'(ex_valid), 64'd1);
      check("t6_ill",   64'(ex_illegal), 64'd1);
      check("t6_rw",    64'(ex_reg_write), 64'd0);

      // ld x4,-8(x1)
      cyc(1, 32'hFF80B203, 64'h2000, 64'd0, 0, 0, 0);
      check("ld_op_b", ex_op_b, 64'hFFFF_FFFF_FFFF_FFF8);
      check("ld_mr",   64'(ex_mem_read), 64'd1);

      // beq x1,x2,+16 and beq x1,x2,-2
      cyc(1, 32'h00208863, 64'd4, 64'd4, 0, 0, 0);
      check("beq_imm", ex_imm, 64'd16);
      check("beq_alu", 64'(ex_alu_sel), 64'(A_SUB));
      check("beq_br",  64'(ex_branch), 64'd1);
      cyc(1, 32'hFE208FE3, 64'd4, 64'd5, 0, 0, 0);
      check("beq_neg_imm", ex_imm, 64'hFFFF_FFFF_FFFF_FFFE);

      // add x0,x1,x2 must not write back
      cyc(1, 32'h00208033, 64'd1, 64'd2, 0, 0, 0);
      check("rd0_rw", 64'(ex_reg_write), 64'd0);

      // Bad funct7, bad slli funct6, then an empty input slot
      cyc(1, 32'h802081B3, 64'd1, 64'd2, 0, 0, 0);
      check("badf7_ill", 64'(ex_illegal), 64'd1);
      cyc(1, 32'h40109093, 64'd1, 64'd2, 0, 0, 0);
      check("badslli_ill", 64'(ex_illegal), 64'd1);
      cyc(0, 32'h002081B3, 64'd1, 64'd2, 0, 0, 0);
      check("bubble_valid", 64'(ex_valid), 64'd0);

      // R-type and I-type sweeps, checked by the model
      for (int k = 0; k < 8; k++) begin
         logic [2:0]  f3;
         logic [11:0] iv;
         f3 = 3'(k);
         cyc(1, {7'b0000000, 5'd2, 5'd1, f3, 5'd3, 7'h33}, 64'h1234_5678 * (k + 1), 64'hFFFF_0000_0000_0000 - 64'(k), 0, 0, 0);
         iv = (k == 1 || k == 5) ? 12'h025 : 12'h8A5 - 12'(k);
         cyc(1, {iv, 5'd1, f3, 5'd4, 7'h13}, 64'd100 + 64'(k), 64'd77, 0, 0, 0);
      end
      cyc(1, 32'h402081B3, 64'd9, 64'd3, 0, 0, 0);
      cyc(1, 32'h4020D1B3, 64'd9, 64'd3, 0, 0, 0);
      check("sra_r_alu", 64'(ex_alu_sel), 64'(A_SRA));

      // Reset mid-stream wins over a simultaneous stall
      cyc(1, 32'h002081B3, 64'd5, 64'd7, 0, 0, 0);
      cyc(1, 32'h0020B423, 64'd5, 64'd7, 1, 0, 1);
      check_all_zero("midrst");
      cyc(1, 32'h002081B3, 64'd15, 64'd16, 0, 0, 0);
      check("post_rst_op_a", ex_op_a, 64'd15);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
